// File: rtl/four_req_arbiter.sv
// four_req_arbiter
// Round-robin arbiter that shares one downstream resource (the OR path over
// requesters a, b, c, d) among four level requesters. A one-hot grant is
// registered and held while the owner keeps requesting, for at most HOLD_MAX
// cycles. Every tenure is followed by exactly one idle (GAP) cycle before the
// next grant.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] level requests, bit0=a .. bit3=d
//   gnt      out  [3:0] registered one-hot grant (or zero)
//   gnt_id   out  [1:0] registered index of current/last owner
//   busy     out  registered, high while gnt is non-zero
//   any_req  out  combinational OR of all requests (wake flag)
//   timeout  out  registered one-cycle pulse when a tenure is force-ended
module four_req_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       any_req,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_id;
    logic             r_busy;
    logic             r_timeout;

    logic [1:0]       w_win_id;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_owner_req;

    assign any_req     = |req;
    assign w_owner_req = req[r_gnt_id];

    // Circular scan starting one past the last owner; the last owner is
    // visited last (i == 4), so it only wins when nobody else is requesting.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = r_gnt_id;
        w_idx    = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_idx = r_gnt_id + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    // Arbiter FSM with registered grant, id, busy and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'd3;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (any_req) begin
                        r_state  <= ST_GRANT;
                        r_gnt    <= 4'b0001 << w_win_id;
                        r_gnt_id <= w_win_id;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A release takes precedence over expiry in the same cycle.
                    if (!w_owner_req) begin
                        r_state <= ST_GAP;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= ST_GAP;
                        r_gnt     <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_four_req_arbiter.sv
// Directed bench for four_req_arbiter. Two instances share req/rst_n:
// u_dut8 (HOLD_MAX=8) and u_dut2 (HOLD_MAX=2). Expected post-edge outputs are
// queued when each request vector is driven and popped after the clock edge.
module tb_four_req_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       to;
        logic       sel2;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt8, gnt2;
    logic [1:0] id8, id2;
    logic       busy8, busy2, any8, any2, to8, to2;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    four_req_arbiter #(.HOLD_MAX(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt8), .gnt_id(id8), .busy(busy8), .any_req(any8), .timeout(to8)
    );

    four_req_arbiter #(.HOLD_MAX(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt2), .gnt_id(id2), .busy(busy2), .any_req(any2), .timeout(to2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the DUT after the next rising edge against the oldest queued entry.
    task automatic expect_next(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            if (e.sel2) begin
                chk({tag, "_gnt"},  8'(gnt2),  8'(e.g));
                chk({tag, "_id"},   8'(id2),   8'(e.id));
                chk({tag, "_busy"}, 8'(busy2), 8'(|e.g));
                chk({tag, "_to"},   8'(to2),   8'(e.to));
            end else begin
                chk({tag, "_gnt"},  8'(gnt8),  8'(e.g));
                chk({tag, "_id"},   8'(id8),   8'(e.id));
                chk({tag, "_busy"}, 8'(busy8), 8'(|e.g));
                chk({tag, "_to"},   8'(to8),   8'(e.to));
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] eid, input logic eto, input logic sel2);
        exp_t e;
        @(negedge clk);
        req = r;
        e.g = eg; e.id = eid; e.to = eto; e.sel2 = sel2;
        sb.push_back(e);
        #1;
        chk({tag, "_any"}, 8'(sel2 ? any2 : any8), 8'(|r));
        expect_next(tag);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_gnt"},  8'(gnt8),  8'h00);
        chk({tag, "_busy"}, 8'(busy8), 8'h00);
        chk({tag, "_to"},   8'(to8),   8'h00);
        chk({tag, "_id"},   8'(id8),   8'h03);
        chk({tag, "_gnt2"}, 8'(gnt2),  8'h00);
        chk({tag, "_id2"},  8'(id2),   8'h03);
    endtask

    initial begin
        exp_t e;
        logic [3:0] g;
        logic [1:0] own;
        int unsigned ph;

        // Reset with all requesters active.
        rst_n = 1'b1;
        req   = 4'b1111;
        #1 rst_n = 1'b0;
        #1;
        reset_check("reset");
        chk("reset_any", 8'(any8), 8'h01);
        repeat (2) @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // Single requester b for three cycles.
        step("single1", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step("single2", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step("single3", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step("single_rel", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        step("single_gap", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        step("single_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

        // Handover a -> d with a one-cycle gap.
        step("hand_a", 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
        step("hand_gap", 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("hand_d", 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0);
        step("hand_rel", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
        step("hand_idle", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

        // c holds for 20 cycles: 8-cycle tenures, timeout, gap, re-grant.
        // Extra non-owner requests mid-tenure must not disturb the owner.
        for (int k = 1; k <= 20; k++) begin
            if (k == 9 || k == 18)
                step("tmo", (k >= 3 && k <= 5) ? 4'b0111 : 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
            else
                step("tmo", (k >= 3 && k <= 5) ? 4'b0111 : 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
        end
        step("tmo_rel", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        step("tmo_idle", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // Reset during the third cycle of a b tenure.
        step("mid_b1", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step("mid_b2", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step("mid_b3", 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        reset_check("mid_rst");
        req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        e.g = 4'b0001; e.id = 2'd0; e.to = 1'b0; e.sel2 = 1'b0;
        sb.push_back(e);
        expect_next("mid_first");
        step("mid_hold", 4'b0011, 4'b0001, 2'd0, 1'b0, 1'b0);
        step("mid_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("mid_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fairness on the HOLD_MAX=2 instance with all four requesting.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            ph  = 32'(k - 1) % 3;
            own = 2'(((k - 1) / 3) % 4);
            g   = 4'b0001 << own;
            if (ph == 2)
                step("fair", 4'b1111, 4'b0000, own, 1'b1, 1'b1);
            else
                step("fair", 4'b1111, g, own, 1'b0, 1'b1);
        end
        // Owner drops on the cycle its tenure would expire: release, no timeout.
        step("fair_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        step("fair_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/four_req_arbiter.md
# four_req_arbiter

Round-robin arbiter and sequencer that shares one downstream resource, the four-input OR path (inputs a, b, c, d), among four requesters. It registers a one-hot grant and holds it while the owner keeps requesting, up to a bounded tenure. It inserts a one-cycle handover gap between owners and exports the combinational OR of all requests as a wake/any-request flag. It sits between the four requesting agents and the shared OR datapath.

## Interface
- HOLD_MAX, default 8: maximum consecutive grant cycles per tenure; legal range 1..2^CNT_W.
- CNT_W, default 4: width of the tenure counter.

- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- req  input  4  level requests; bit0=a, bit1=b, bit2=c, bit3=d.
- gnt  output  4  registered one-hot grant, or all-zero.
- gnt_id  output  2  registered index of the current or last owner.
- busy  output  1  registered; high while any gnt bit is high.
- any_req  output  1  combinational OR of req[3:0] (a|b|c|d).
- timeout  output  1  registered one-cycle pulse when a tenure is force-ended.

## Operation
- Reset values (async, immediate on rst_n low): gnt=0, gnt_id=3, busy=0, timeout=0, state=IDLE, tenure counter=0, priority pointer=3. With gnt_id=3, requester a (bit0) has top priority after reset.
- FSM states:
  - IDLE: gnt=0. If any_req, pick a winner, go to GRANT, load gnt/gnt_id, clear the counter.
  - GRANT: gnt holds the owner.
    - req[owner]=0: drop gnt, go to GAP.
    - Counter reaches HOLD_MAX-1 while req[owner]=1: drop gnt, pulse timeout, go to GAP.
    - Otherwise: increment the counter.
  - GAP: gnt=0 for exactly one cycle. If any_req, pick a winner and go to GRANT; else go to IDLE.
- Winner selection: first set bit of req, scanning circularly from gnt_id+1 (wrap 3->0). gnt_id updates to the winner. The previous owner is therefore lowest priority; this also applies after a timeout.
- Timed-out owner with req still high: it competes normally in GAP. If it is the sole requester, it is re-granted.
- busy = |gnt, registered with gnt. any_req is purely combinational with no register.
- gnt is never multi-hot. gnt is never high while state is IDLE or GAP.
- Requests from non-owners during GRANT are ignored until GAP. Changes to non-owner req bits do not affect the tenure.

## Timing
- req to gnt latency from IDLE: req sampled high at edge N gives gnt high after edge N.
- Release: owner req low sampled at edge N gives gnt low after N. GAP spans N..N+1. The next gnt is high after edge N+1. Handover gap is exactly one cycle.
- Tenure: gnt is high for at most HOLD_MAX cycles. timeout is high in the first GAP cycle only.
- HOLD_MAX=1: every grant lasts one cycle, then GAP. A continuous requester gets a 50% duty grant.
- Simultaneous requests: resolved in one cycle by the round-robin rule; no extra latency.
- Owner drop and counter expiry in the same cycle: treated as a release. timeout stays 0.
- Reset asserted mid-GRANT: gnt, busy, and timeout go low immediately without waiting for clk. After deassertion, the FSM resumes in IDLE with pointer=3.
- rst_n deassertion is synchronised externally. The block does not re-synchronise it.

## Test plan
- Reset: assert rst_n=0 with req=4'b1111 -> gnt=0, busy=0, timeout=0, gnt_id=3, any_req=1.
- Single requester: req=4'b0010 for 3 cycles then 0 -> gnt=4'b0010 one cycle after req, held 3 cycles, then gnt=0; FSM returns to IDLE via GAP.
- Fairness: req=4'b1111 held, HOLD_MAX=2 -> grant sequence 0001,0010,0100,1000,0001. Each grant lasts 2 cycles, each grant is followed by a 1-cycle gap, and timeout pulses after each tenure.
- Timeout: req=4'b0100 held 20 cycles, HOLD_MAX=8 -> gnt high for 8 cycles, timeout high 1 cycle, gap, re-grant to c; repeats.
- Handover: owner a drops req while d raises req in the same cycle -> gnt=0 for one cycle, then gnt=4'b1000.
- Reset mid-tenure: rst_n low during cycle 3 of a b tenure -> gnt=0 asynchronously. After release with req=4'b0011, the first grant goes to a.
